dma_dmem_req_seq: RTL
=====================

# dma_dmem_req_seq

Parametrised DMA local-side sequencer for the vanilla core's DMEM. It converts a byte-granular transfer descriptor into a sequence of word requests with byte masks, covering unaligned start and end addresses. In pull mode it writes DMEM from an incoming data stream. In push mode it reads DMEM into an outgoing, back-pressured data stream. It sits between the DMA controller (descriptor and status) and the DMEM arbitration port.

## Interface
- data_width_p, 32, DMEM word width in bits; must be a multiple of 8.
- dmem_size_p, 1024, DMEM depth in words.
- len_width_p, 12, width of the transfer byte count.
- dmem_addr_width_lp, clog2(dmem_size_p), word address width.
- mask_width_lp, data_width_p/8, bytes per word.
- boff_width_lp, clog2(mask_width_lp), byte-offset width.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  descriptor valid; sampled only in IDLE.
- push_not_pull_i  in  1  1 = DMEM read to out stream; 0 = in stream to DMEM write.
- base_byte_addr_i  in  dmem_addr_width_lp+boff_width_lp  start byte address.
- num_bytes_i  in  len_width_p  transfer length in bytes.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- dmem_v_o / dmem_w_o  out  1 / 1  DMEM request valid / write.
- dmem_addr_o  out  dmem_addr_width_lp  word address.
- dmem_mask_o  out  mask_width_lp  byte enables.
- dmem_data_o  out  data_width_p  write data.
- dmem_yumi_i  in  1  request accepted this cycle.
- dmem_rdata_i  in  data_width_p  read data; valid the cycle after a read is yumi'd.
- in_v_i / in_data_i / in_yumi_o  in / in / out  1 / data_width_p / 1  pull-mode source stream.
- out_v_o / out_data_o / out_mask_o / out_last_o / out_ready_i  out / out / out / out / in  1 / data_width_p / mask_width_lp / 1 / 1  push-mode sink stream.

## Operation
- Latching on start:
  - Word address = base_byte_addr_i >> boff_width_lp.
  - Offset = low boff_width_lp bits of base_byte_addr_i.
  - Word count = ceil((offset + num_bytes_i) / mask_width_lp), computed at len_width_p+1 bits.
- Byte masks:
  - First word: bits [offset .. mask_width_lp-1] set.
  - Last word: bits [0 .. ((offset + num_bytes_i - 1) mod mask_width_lp)] set.
  - A single-word transfer uses the AND of the first and last masks.
  - Middle words: all ones.
- Data is never rotated or aligned; the mask alone selects bytes.
- Word address increments after each accepted request and wraps modulo dmem_size_p (dmem_size_p is a power of two).
- States:
  - IDLE, on start_i with num_bytes_i == 0: go to DONE. No requests are issued.
  - IDLE, on start_i with num_bytes_i != 0: go to ISSUE.
  - ISSUE, when the last request is yumi'd: pull mode goes to DONE; push mode goes to DRAIN.
  - DRAIN: go to DONE once the read buffer is empty and no read is in flight.
  - DONE: lasts exactly 1 cycle, asserts done_o, then goes to IDLE.
- Pull mode:
  - dmem_v_o = ISSUE & in_v_i; dmem_w_o = 1; dmem_data_o = in_data_i.
  - in_yumi_o = dmem_yumi_i. This is a combinational pass-through; dmem_yumi_i must not depend on in_yumi_o.
- Push mode:
  - dmem_w_o = 0; in_yumi_o = 0.
  - A 2-entry buffer holds {data, mask, last}.
  - A read is issued only while (buffer occupancy + reads in flight) < 2.
  - Read data enqueues one cycle after its yumi.
  - out_* present the buffer head; it dequeues on out_v_o & out_ready_i.
  - out_last_o is set on the final word only.
- start_i outside IDLE is ignored. Descriptor inputs are don't-care outside the start cycle.

## Timing
- Reset (asynchronous) values:
  - State = IDLE; buffer and counters cleared.
  - All outputs 0: busy_o, done_o, dmem_v_o, dmem_w_o, dmem_addr_o, dmem_mask_o, dmem_data_o (pull mode, in_data_i = 0), in_yumi_o, out_v_o, out_data_o, out_mask_o, out_last_o.
  - Reset mid-transfer abandons the transfer with no done_o. Read data arriving the cycle after reset deasserts is dropped.
- Start latency: start_i at cycle N gives the first dmem_v_o at N+1 (pull mode also requires in_v_i).
- Push-mode data path: a read yumi'd at cycle N is enqueued at N+1 and appears on out_v_o at N+1 (bypass into an empty buffer allowed) or later.
- With out_ready_i held high and dmem_yumi_i always high, sustained push throughput is 1 word per cycle.
- done_o timing:
  - Pull: asserts the cycle after the last write is yumi'd.
  - Push: asserts the cycle after the last out handshake.
  - Zero length: asserts at N+1.
- Simultaneous enqueue and dequeue on a full buffer is legal; occupancy is unchanged.

## Test plan
- Pull aligned: base 0x010, 8 bytes, in_v_i=1, yumi=1 -> writes addr 4 then addr 5, mask 4'b1111 both; done_o at the cycle after the second yumi.
- Pull unaligned: base 0x011, 6 bytes -> addr 4 mask 4'b1110, addr 5 mask 4'b0111. With in_v_i toggling every other cycle, no write is issued while in_v_i is 0.
- Push with back-pressure: base 0x000, 16 bytes, out_ready_i low for 10 cycles -> exactly 2 reads issued, then stall. On release, out delivers words 0..3 in order, out_last_o only on word 3, done_o one cycle after the last handshake.
- Zero length and single word:
  - num_bytes 0 -> no dmem_v_o, done_o at N+1.
  - base 0x005, 2 bytes -> one request, addr 1, mask 4'b0110.
- Wrap: dmem_size_p 1024, base 0xFFE, 4 bytes -> addr 1023 mask 4'b1100, then addr 0 mask 4'b0011.
- Reset: assert reset_i asynchronously mid-push with one read in flight -> all outputs 0 immediately, no done_o. A following start runs cleanly.

Source files
------------

// File: rtl/dma_dmem_req_seq.sv
// DMA local-side DMEM sequencer: turns a byte-granular descriptor into masked word requests.
// Pull mode writes DMEM from an input stream; push mode reads DMEM into a back-pressured stream.
module dma_dmem_req_seq #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned dmem_size_p  = 1024,
  parameter int unsigned len_width_p  = 12,
  localparam int unsigned dmem_addr_width_lp = $clog2(dmem_size_p),
  localparam int unsigned mask_width_lp      = data_width_p / 8,
  localparam int unsigned boff_width_lp      = $clog2(mask_width_lp)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic                                        start_i,
  input  logic                                        push_not_pull_i,
  input  logic [dmem_addr_width_lp+boff_width_lp-1:0] base_byte_addr_i,
  input  logic [len_width_p-1:0]                      num_bytes_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        dmem_v_o,
  output logic                                        dmem_w_o,
  output logic [dmem_addr_width_lp-1:0]               dmem_addr_o,
  output logic [mask_width_lp-1:0]                    dmem_mask_o,
  output logic [data_width_p-1:0]                     dmem_data_o,
  input  logic                                        dmem_yumi_i,
  input  logic [data_width_p-1:0]                     dmem_rdata_i,
  input  logic                                        in_v_i,
  input  logic [data_width_p-1:0]                     in_data_i,
  output logic                                        in_yumi_o,
  output logic                                        out_v_o,
  output logic [data_width_p-1:0]                     out_data_o,
  output logic [mask_width_lp-1:0]                    out_mask_o,
  output logic                                        out_last_o,
  input  logic                                        out_ready_i
);

  localparam int unsigned cnt_width_lp = len_width_p + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic                          push_q;
  logic [dmem_addr_width_lp-1:0] addr_q;
  logic [cnt_width_lp-1:0]       words_left_q;
  logic                          first_q;
  logic [mask_width_lp-1:0]      first_mask_q, last_mask_q;

  logic                          inflight_q, inflight_d;
  logic [mask_width_lp-1:0]      inflight_mask_q;
  logic                          inflight_last_q;

  logic [data_width_p-1:0]       buf_data_q [2];
  logic [mask_width_lp-1:0]      buf_mask_q [2];
  logic                          buf_last_q [2];
  logic                          wr_ptr_q, rd_ptr_q;
  logic [1:0]                    count_q, count_d;

  // Descriptor decode, only meaningful in the start cycle.
  logic [boff_width_lp-1:0]      start_off, end_off;
  logic [cnt_width_lp-1:0]       total_bytes, start_words;
  logic [mask_width_lp-1:0]      start_first_mask, start_last_mask;
  logic                          start_fire;

  assign start_fire  = (state_q == StIdle) & start_i;
  assign start_off   = base_byte_addr_i[boff_width_lp-1:0];
  assign total_bytes = cnt_width_lp'(start_off) + cnt_width_lp'(num_bytes_i);
  // Ceiling division without widening past cnt_width_lp.
  assign start_words = (total_bytes >> boff_width_lp)
                     + cnt_width_lp'(|total_bytes[boff_width_lp-1:0]);
  assign end_off     = boff_width_lp'(total_bytes - cnt_width_lp'(1));

  always_comb begin
    start_first_mask = '0;
    start_last_mask  = '0;
    for (int unsigned i = 0; i < mask_width_lp; i++) begin
      start_first_mask[i] = boff_width_lp'(i) >= start_off;
      start_last_mask[i]  = boff_width_lp'(i) <= end_off;
    end
  end

  // Request side.
  logic                     last_word, room, req_v, accept;
  logic [mask_width_lp-1:0] cur_mask;

  assign last_word = (words_left_q == cnt_width_lp'(1));

  always_comb begin
    cur_mask = '1;
    if (first_q)   cur_mask = cur_mask & first_mask_q;
    if (last_word) cur_mask = cur_mask & last_mask_q;
  end

  // Buffered words plus the read in flight must never exceed the two buffer slots.
  assign room   = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
  assign req_v  = (state_q == StIssue) & (push_q ? room : in_v_i);
  assign accept = req_v & dmem_yumi_i;

  assign inflight_d = push_q & accept;

  // Output stream: buffer head, or bypass of the returning read when the buffer is empty.
  logic buf_enq, buf_deq;

  assign out_v_o = (count_q != 2'd0) | inflight_q;
  assign buf_deq = (count_q != 2'd0) & out_ready_i;
  assign buf_enq = inflight_q & ~((count_q == 2'd0) & out_ready_i);

  always_comb begin
    count_d = count_q;
    if (buf_enq) count_d = count_d + 2'd1;
    if (buf_deq) count_d = count_d - 2'd1;
  end

  always_comb begin
    out_data_o = '0;
    out_mask_o = '0;
    out_last_o = 1'b0;
    if (count_q != 2'd0) begin
      out_data_o = buf_data_q[rd_ptr_q];
      out_mask_o = buf_mask_q[rd_ptr_q];
      out_last_o = buf_last_q[rd_ptr_q];
    end else if (inflight_q) begin
      out_data_o = dmem_rdata_i;
      out_mask_o = inflight_mask_q;
      out_last_o = inflight_last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (num_bytes_i == '0) ? StDone : StIssue;
      end
      StIssue: begin
        if (accept && last_word) state_d = push_q ? StDrain : StDone;
      end
      StDrain: begin
        if (count_d == 2'd0 && !inflight_d) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      push_q          <= 1'b0;
      addr_q          <= '0;
      words_left_q    <= '0;
      first_q         <= 1'b0;
      first_mask_q    <= '0;
      last_mask_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_mask_q <= '0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (accept) begin
        inflight_mask_q <= cur_mask;
        inflight_last_q <= last_word;
      end
      if (start_fire) begin
        push_q       <= push_not_pull_i;
        addr_q       <= base_byte_addr_i[dmem_addr_width_lp+boff_width_lp-1:boff_width_lp];
        words_left_q <= start_words;
        first_q      <= 1'b1;
        first_mask_q <= start_first_mask;
        last_mask_q  <= start_last_mask;
      end else if (accept) begin
        addr_q       <= addr_q + dmem_addr_width_lp'(1);
        words_left_q <= words_left_q - cnt_width_lp'(1);
        first_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_mask_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (buf_enq) begin
        buf_data_q[wr_ptr_q] <= dmem_rdata_i;
        buf_mask_q[wr_ptr_q] <= inflight_mask_q;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (buf_deq) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign dmem_v_o    = req_v;
  assign dmem_w_o    = (state_q == StIssue) & ~push_q;
  assign dmem_addr_o = addr_q;
  assign dmem_mask_o = (state_q == StIssue) ? cur_mask : '0;
  assign dmem_data_o = push_q ? '0 : in_data_i;
  // Pull-mode accept is forwarded straight to the source stream.
  assign in_yumi_o   = accept & ~push_q;

endmodule
